// File: rtl/set_bit_scanner_pkg.sv
// Shared widths and FSM state encoding for the set-bit scanner.
package set_bit_scanner_pkg;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned IDX_W = 5;
  localparam int unsigned CNT_W = IDX_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/set_bit_scanner_if.sv
// Load / index-stream / completion bundle between a consumer and the scanner.
interface set_bit_scanner_if;
  import set_bit_scanner_pkg::*;

  logic             start;
  logic [WIDTH-1:0] data_in;
  logic             ready;
  logic             idx_valid;
  logic [IDX_W-1:0] idx;
  logic             idx_ready;
  logic             done;
  logic [CNT_W-1:0] count;

  modport master (
    output start, data_in, idx_ready,
    input  ready, idx_valid, idx, done, count
  );

  modport slave (
    input  start, data_in, idx_ready,
    output ready, idx_valid, idx, done, count
  );

endinterface

// File: rtl/set_bit_scanner_lowest_set_bit_encoder.sv
// Combinational lowest-set-bit finder: index, one-hot mask and empty flag.
// Pairs are merged level by level, so depth is log2(WIDTH) 2:1 stages.
module lowest_set_bit_encoder
  import set_bit_scanner_pkg::*;
(
  input  logic [WIDTH-1:0] vec_i,
  output logic [IDX_W-1:0] idx_o,
  output logic [WIDTH-1:0] mask_o,
  output logic             none_o
);

  logic [WIDTH-1:0] v_c;
  logic [IDX_W-1:0] ix_c [WIDTH];

  // In-place reduction: node n of level l reads nodes 2n/2n+1 of level l-1.
  always_comb begin
    v_c = vec_i;
    for (int n = 0; n < WIDTH; n++) begin
      ix_c[IDX_W'(n)] = '0;
    end
    for (int l = 1; l <= IDX_W; l++) begin
      for (int n = 0; n < (WIDTH >> l); n++) begin
        ix_c[IDX_W'(n)] = v_c[IDX_W'(2*n)] ? ix_c[IDX_W'(2*n)]
                        : (ix_c[IDX_W'(2*n+1)] | IDX_W'(1 << (l-1)));
        v_c[IDX_W'(n)]  = v_c[IDX_W'(2*n)] | v_c[IDX_W'(2*n+1)];
      end
    end
  end

  assign idx_o  = ix_c[0];
  assign none_o = ~v_c[0];
  assign mask_o = none_o ? '0 : (WIDTH'(1) << idx_o);

endmodule

// File: rtl/set_bit_scanner.sv
// Walks a loaded word and streams the index of each set bit, lowest first,
// then pulses done with the number of beats transferred.
module set_bit_scanner
  import set_bit_scanner_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  set_bit_scanner_if.slave   bus
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] mask_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic [IDX_W-1:0] idx_q;
  logic             ready_q, idx_valid_q, done_q;
  logic             ready_d, idx_valid_d, done_d;

  logic [IDX_W-1:0] enc_idx;
  logic [WIDTH-1:0] enc_mask;
  logic             enc_none;

  // Encoder looks at the next remaining word so idx/mask are ready as registers.
  lowest_set_bit_encoder u_enc (
    .vec_i  (rem_d),
    .idx_o  (enc_idx),
    .mask_o (enc_mask),
    .none_o (enc_none)
  );

  // Remaining-word and beat-count update.
  always_comb begin
    rem_d   = rem_q;
    count_d = count_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          rem_d   = bus.data_in;
          count_d = '0;
        end
      end
      ST_SCAN: begin
        if (bus.idx_ready) begin
          rem_d   = rem_q & ~mask_q;
          count_d = count_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Next state and next registered outputs.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.start) state_d = enc_none ? ST_DONE : ST_SCAN;
      ST_SCAN: if (bus.idx_ready && enc_none) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    ready_d     = (state_d == ST_IDLE);
    idx_valid_d = (state_d == ST_SCAN);
    done_d      = (state_d == ST_DONE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      rem_q       <= '0;
      mask_q      <= '0;
      count_q     <= '0;
      idx_q       <= '0;
      ready_q     <= 1'b1;
      idx_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      mask_q      <= enc_mask;
      count_q     <= count_d;
      idx_q       <= enc_idx;
      ready_q     <= ready_d;
      idx_valid_q <= idx_valid_d;
      done_q      <= done_d;
    end
  end

  assign bus.ready     = ready_q;
  assign bus.idx_valid = idx_valid_q;
  assign bus.idx       = idx_q;
  assign bus.done      = done_q;
  assign bus.count     = count_q;

endmodule

// File: tb/tb_set_bit_scanner.sv
// Directed bench for set_bit_scanner: inputs driven and outputs sampled on the falling edge.
module tb_set_bit_scanner;
  import set_bit_scanner_pkg::*;

  logic clock = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  set_bit_scanner_if bus();

  set_bit_scanner dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Present a word for one edge; returns in the cycle after the load edge.
  task automatic load(input logic [31:0] w);
    bus.start   = 1'b1;
    bus.data_in = w;
    @(negedge clock);
    bus.start   = 1'b0;
    bus.data_in = 32'hDEAD_BEEF;
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.start = 1'b0; bus.data_in = '0; bus.idx_ready = 1'b0;
    repeat (2) @(negedge clock);
    total++; if (bus.ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", bus.ready); end
    total++; if (bus.idx_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", bus.idx_valid); end
    total++; if (bus.idx !== 5'd0) begin bad++; $display("FAIL reset_idx: got %0d want 0", bus.idx); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", bus.done); end
    total++; if (bus.count !== 6'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", bus.count); end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_zero_word();
    total++; if (bus.ready !== 1'b1) begin bad++; $display("FAIL zero_pre_ready: got %b want 1", bus.ready); end
    load(32'h0000_0000);
    total++; if (bus.idx_valid !== 1'b0) begin bad++; $display("FAIL zero_valid: got %b want 0", bus.idx_valid); end
    total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL zero_done: got %b want 1", bus.done); end
    total++; if (bus.count !== 6'd0) begin bad++; $display("FAIL zero_count: got %0d want 0", bus.count); end
    total++; if (bus.ready !== 1'b0) begin bad++; $display("FAIL zero_ready_in_done: got %b want 0", bus.ready); end
    @(negedge clock);
    total++; if ({bus.ready, bus.done} !== 2'b10) begin bad++; $display("FAIL zero_back_idle: got ready/done=%b want 10", {bus.ready, bus.done}); end
  endtask

  task automatic test_two_ends();
    bus.idx_ready = 1'b1;
    load(32'h8000_0001);
    total++; if ({bus.idx_valid, bus.idx} !== {1'b1, 5'd0}) begin bad++; $display("FAIL ends_beat0: got v=%b idx=%0d want v=1 idx=0", bus.idx_valid, bus.idx); end
    @(negedge clock);
    total++; if ({bus.idx_valid, bus.idx} !== {1'b1, 5'd31}) begin bad++; $display("FAIL ends_beat1: got v=%b idx=%0d want v=1 idx=31", bus.idx_valid, bus.idx); end
    @(negedge clock);
    total++; if ({bus.idx_valid, bus.done, bus.count} !== {1'b0, 1'b1, 6'd2}) begin bad++; $display("FAIL ends_done: got v=%b done=%b count=%0d want v=0 done=1 count=2", bus.idx_valid, bus.done, bus.count); end
    @(negedge clock);
    total++; if ({bus.ready, bus.done} !== 2'b10) begin bad++; $display("FAIL ends_idle: got ready/done=%b want 10", {bus.ready, bus.done}); end
  endtask

  task automatic test_back_to_back();
    bus.idx_ready = 1'b1;
    load(32'hFFFF_FFFF);
    for (int i = 0; i < 32; i++) begin
      total++;
      if ({bus.idx_valid, bus.idx} !== {1'b1, 5'(i)}) begin
        bad++; $display("FAIL b2b_beat%0d: got v=%b idx=%0d want v=1 idx=%0d", i, bus.idx_valid, bus.idx, i);
      end
      @(negedge clock);
    end
    total++; if ({bus.idx_valid, bus.done, bus.count} !== {1'b0, 1'b1, 6'd32}) begin bad++; $display("FAIL b2b_done: got v=%b done=%b count=%0d want v=0 done=1 count=32", bus.idx_valid, bus.done, bus.count); end
    @(negedge clock);
    total++; if (bus.ready !== 1'b1) begin bad++; $display("FAIL b2b_idle: got ready=%b want 1", bus.ready); end
  endtask

  task automatic test_backpressure();
    bus.idx_ready = 1'b0;
    load(32'h0000_0012);
    for (int k = 0; k < 4; k++) begin
      total++;
      if ({bus.idx_valid, bus.idx, bus.count} !== {1'b1, 5'd1, 6'd0}) begin
        bad++; $display("FAIL bp_hold%0d: got v=%b idx=%0d count=%0d want v=1 idx=1 count=0", k, bus.idx_valid, bus.idx, bus.count);
      end
      if (k == 3) bus.idx_ready = 1'b1;
      @(negedge clock);
    end
    total++; if ({bus.idx_valid, bus.idx} !== {1'b1, 5'd4}) begin bad++; $display("FAIL bp_beat1: got v=%b idx=%0d want v=1 idx=4", bus.idx_valid, bus.idx); end
    @(negedge clock);
    total++; if ({bus.done, bus.count} !== {1'b1, 6'd2}) begin bad++; $display("FAIL bp_done: got done=%b count=%0d want done=1 count=2", bus.done, bus.count); end
    @(negedge clock);
  endtask

  task automatic test_start_ignored();
    bus.idx_ready = 1'b0;
    load(32'h0000_0300);
    total++; if ({bus.idx_valid, bus.idx} !== {1'b1, 5'd8}) begin bad++; $display("FAIL ign_beat0: got v=%b idx=%0d want v=1 idx=8", bus.idx_valid, bus.idx); end
    bus.start = 1'b1; bus.data_in = 32'h0000_00FF; bus.idx_ready = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    total++; if ({bus.idx_valid, bus.idx} !== {1'b1, 5'd9}) begin bad++; $display("FAIL ign_beat1: got v=%b idx=%0d want v=1 idx=9", bus.idx_valid, bus.idx); end
    @(negedge clock);
    total++; if ({bus.done, bus.count, bus.ready} !== {1'b1, 6'd2, 1'b0}) begin bad++; $display("FAIL ign_done: got done=%b count=%0d ready=%b want done=1 count=2 ready=0", bus.done, bus.count, bus.ready); end
    bus.start = 1'b1; bus.data_in = 32'h0000_00FF;
    @(negedge clock);
    bus.start = 1'b0;
    total++; if ({bus.ready, bus.done, bus.idx_valid} !== 3'b100) begin bad++; $display("FAIL ign_done_start: got ready/done/v=%b want 100", {bus.ready, bus.done, bus.idx_valid}); end
    @(negedge clock);
    total++; if ({bus.ready, bus.done, bus.idx_valid} !== 3'b100) begin bad++; $display("FAIL ign_still_idle: got ready/done/v=%b want 100", {bus.ready, bus.done, bus.idx_valid}); end
  endtask

  task automatic test_reset_mid_scan();
    bus.idx_ready = 1'b1;
    load(32'h0000_0007);
    total++; if ({bus.idx_valid, bus.idx} !== {1'b1, 5'd0}) begin bad++; $display("FAIL rst_beat0: got v=%b idx=%0d want v=1 idx=0", bus.idx_valid, bus.idx); end
    @(negedge clock);
    total++; if ({bus.idx_valid, bus.idx} !== {1'b1, 5'd1}) begin bad++; $display("FAIL rst_beat1: got v=%b idx=%0d want v=1 idx=1", bus.idx_valid, bus.idx); end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    total++; if ({bus.idx_valid, bus.done, bus.count, bus.ready, bus.idx} !== {1'b0, 1'b0, 6'd0, 1'b1, 5'd0}) begin
      bad++; $display("FAIL rst_clear: got v=%b done=%b count=%0d ready=%b idx=%0d want v=0 done=0 count=0 ready=1 idx=0", bus.idx_valid, bus.done, bus.count, bus.ready, bus.idx);
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      total++; if ({bus.done, bus.idx_valid} !== 2'b00) begin bad++; $display("FAIL rst_no_done%0d: got done/v=%b want 00", k, {bus.done, bus.idx_valid}); end
    end
    load(32'h0000_0004);
    total++; if ({bus.idx_valid, bus.idx} !== {1'b1, 5'd2}) begin bad++; $display("FAIL rst_new_beat: got v=%b idx=%0d want v=1 idx=2", bus.idx_valid, bus.idx); end
    @(negedge clock);
    total++; if ({bus.done, bus.count} !== {1'b1, 6'd1}) begin bad++; $display("FAIL rst_new_done: got done=%b count=%0d want done=1 count=1", bus.done, bus.count); end
    @(negedge clock);
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 1'b0;
    bus.data_in = '0;
    bus.idx_ready = 1'b0;
    @(negedge clock);
    test_reset();
    test_zero_word();
    test_two_ends();
    test_back_to_back();
    test_backpressure();
    test_start_ignored();
    test_reset_mid_scan();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
